// File: rtl/sti_pkg.sv
// Shared STI definitions: transaction FSM states and bus widths.
// Imported by the memory responder, the peripheral responder and the MAU.
package sti_pkg;

  localparam int STI_DATA_W = 16;
  localparam int STI_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sti_state_e;

endpackage

// File: rtl/sti_mem_array.sv
// Single-port word-addressed synchronous RAM with a registered read port.
// Contents are never reset.
module sti_mem_array #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/sti_mem_resp.sv
// STI slave memory responder: one transaction at a time, completed after WAIT_CYCLES wait states.
// Optional write protection below WP_LIMIT is compiled in with STI_MEM_RESP_WP_EN.
module sti_mem_resp
  import sti_pkg::*;
#(
  parameter int                    ADDR_W      = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [STI_ADDR_W-1:0] WP_LIMIT    = 16'h3000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_txn,
  input  logic                  wtxn,
  input  logic [STI_ADDR_W-1:0] addr,
  input  logic [STI_DATA_W-1:0] wdata,
`ifdef STI_MEM_RESP_WP_EN
  input  logic                  wp_en,
  output logic                  wp_fault,
`endif
  output logic [STI_DATA_W-1:0] rdata,
  output logic                  rdy,
  output logic                  busy
);

  // Counter is loaded with WAIT_CYCLES+1 so the access edge lands WAIT_CYCLES+1 edges after acceptance.
  localparam int             CNT_W    = 9;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sti_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wtxn_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [STI_DATA_W-1:0] wdata_q;
  logic [STI_DATA_W-1:0] rdata_q;
  logic                  rdy_q;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  complete;
  logic                  wp_block;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [STI_DATA_W-1:0] mem_rdata;

  // Upper address bits alias when ADDR_W < STI_ADDR_W.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr;

  always_comb begin
    accept   = init_txn && ((state_q == IDLE) || (state_q == RESP));
    complete = (state_q == WAIT) && (cnt_q == CNT_ONE);
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (complete) begin
          state_d = RESP;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef STI_MEM_RESP_WP_EN
  assign wp_block = wp_en && (STI_ADDR_W'(addr_q) < WP_LIMIT);
`else
  logic unused_wp_limit;
  assign unused_wp_limit = ^WP_LIMIT;
  assign wp_block        = 1'b0;
`endif

  // RAM has no reset, so a reset on the access edge must suppress the write itself.
  assign mem_we = complete && wtxn_q && !wp_block && !rst;

  // Steering the live address on acceptance keeps the registered read in time for zero wait states.
  assign mem_addr = accept ? addr[ADDR_W-1:0] : addr_q;

  sti_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (STI_DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= complete;
      busy_q  <= busy_d;
      if (complete && !wtxn_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wtxn_q  <= wtxn;
      addr_q  <= addr[ADDR_W-1:0];
      wdata_q <= wdata;
    end
  end

`ifdef STI_MEM_RESP_WP_EN
  logic wp_fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_fault_q <= 1'b0;
    end else begin
      wp_fault_q <= complete && wtxn_q && wp_block;
    end
  end

  assign wp_fault = wp_fault_q;
`endif

  assign rdata = rdata_q;
  assign rdy   = rdy_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sti_mem_resp.sv
// Directed bench for sti_mem_resp: three instances (2 waits, 0 waits, 8-bit address with 1 wait).
// Write-protect steps run only when STI_MEM_RESP_WP_EN is defined.
module tb_sti_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  init_v;
  logic        wtxn;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [2:0]  rdy_v;
  logic [2:0]  busy_v;
  logic [15:0] rdata_v [3];
`ifdef STI_MEM_RESP_WP_EN
  logic        wp_en;
  logic [2:0]  wp_fault_v;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sti_mem_resp #(.ADDR_W(16), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .init_txn(init_v[0]), .wtxn(wtxn), .addr(addr), .wdata(wdata),
`ifdef STI_MEM_RESP_WP_EN
    .wp_en(wp_en), .wp_fault(wp_fault_v[0]),
`endif
    .rdata(rdata_v[0]), .rdy(rdy_v[0]), .busy(busy_v[0])
  );

  sti_mem_resp #(.ADDR_W(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .init_txn(init_v[1]), .wtxn(wtxn), .addr(addr), .wdata(wdata),
`ifdef STI_MEM_RESP_WP_EN
    .wp_en(wp_en), .wp_fault(wp_fault_v[1]),
`endif
    .rdata(rdata_v[1]), .rdy(rdy_v[1]), .busy(busy_v[1])
  );

  sti_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(1)) u_c (
    .clk(clk), .rst(rst), .init_txn(init_v[2]), .wtxn(wtxn), .addr(addr), .wdata(wdata),
`ifdef STI_MEM_RESP_WP_EN
    .wp_en(wp_en), .wp_fault(wp_fault_v[2]),
`endif
    .rdata(rdata_v[2]), .rdy(rdy_v[2]), .busy(busy_v[2])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction, scramble the inputs after acceptance, wait (bounded) for rdy.
  // Returns sampled in the rdy cycle so the caller may issue back-to-back.
  task automatic txn(input int d, input logic wr, input logic [15:0] ad, input logic [15:0] wd,
                     input int exp_lat, input string tag);
    int lat;
    bit seen;
    init_v[d] = 1'b1;
    wtxn      = wr;
    addr      = ad;
    wdata     = wd;
    tick();
    init_v[d] = 1'b0;
    wtxn      = ~wr;
    addr      = ~ad;
    wdata     = ~wd;
    lat       = 1;
    seen      = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rdy_v[d]) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    $display("txn dut=%0d wr=%0b addr=%h wdata=%h rdata=%h lat=%0d", d, wr, ad, wd, rdata_v[d], lat);
  endtask

  // Each table row is {wr, addr, wdata, expected rdata in the rdy cycle}.
  logic        b_wr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] b_ad [4] = '{16'h0010, 16'h0011, 16'h0010, 16'h0011};
  logic [15:0] b_wd [4] = '{16'h00AA, 16'h00BB, 16'h0000, 16'h0000};
  logic [15:0] b_rd [4] = '{16'h0000, 16'h0000, 16'h00AA, 16'h00BB};

  initial begin
    int rc;
    rst    = 1'b1;
    init_v = '0;
    wtxn   = 1'b0;
    addr   = '0;
    wdata  = '0;
`ifdef STI_MEM_RESP_WP_EN
    wp_en  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_rdy", 16'(rdy_v[0]), 16'h0);
    chk("rst_busy", 16'(busy_v[0]), 16'h0);
    chk("rst_rdata", rdata_v[0], 16'h0000);
`ifdef STI_MEM_RESP_WP_EN
    chk("rst_wp_fault", 16'(wp_fault_v[0]), 16'h0);
`endif
    rst = 1'b0;

    // Step 1: write x1234 @x3000, explicit cycle-by-cycle latency.
    init_v[0] = 1'b1; wtxn = 1'b1; addr = 16'h3000; wdata = 16'h1234;
    tick();
    init_v[0] = 1'b0; wtxn = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("t1_busy_e%0d", e), 16'(busy_v[0]), 16'h1);
      chk($sformatf("t1_rdy_e%0d", e), 16'(rdy_v[0]), 16'h0);
      tick();
    end
    chk("t1_rdy_e3", 16'(rdy_v[0]), 16'h1);
    chk("t1_busy_e3", 16'(busy_v[0]), 16'h0);
    chk("t1_rdata_after_write", rdata_v[0], 16'h0000);
    $display("txn dut=0 wr=1 addr=3000 wdata=1234 rdy at edge 3");
    tick();
    chk("t1_rdy_one_wide", 16'(rdy_v[0]), 16'h0);
    txn(0, 1'b0, 16'h3000, 16'h0000, 4, "t1_read");
    chk("t1_read_data", rdata_v[0], 16'h1234);

    // Step 2: zero wait states, each request issued in the previous rdy cycle.
    for (int k = 0; k < 4; k++) begin
      init_v[1] = 1'b1; wtxn = b_wr[k]; addr = b_ad[k]; wdata = b_wd[k];
      tick();
      init_v[1] = 1'b0;
      chk($sformatf("t2_busy_%0d", k), 16'(busy_v[1]), 16'h1);
      chk($sformatf("t2_norody_%0d", k), 16'(rdy_v[1]), 16'h0);
      tick();
      chk($sformatf("t2_rdy_%0d", k), 16'(rdy_v[1]), 16'h1);
      chk($sformatf("t2_rdata_%0d", k), rdata_v[1], b_rd[k]);
      $display("txn dut=1 wr=%0b addr=%h wdata=%h rdata=%h", b_wr[k], b_ad[k], b_wd[k], rdata_v[1]);
    end

    // Step 3: request pulsed during WAIT is dropped.
    txn(0, 1'b1, 16'h3101, 16'h0001, 4, "t3_pre");
    init_v[0] = 1'b1; wtxn = 1'b1; addr = 16'h3100; wdata = 16'h7777;
    tick();
    init_v[0] = 1'b0;
    tick();
    init_v[0] = 1'b1; wtxn = 1'b1; addr = 16'h3101; wdata = 16'h8888;
    tick();
    init_v[0] = 1'b0;
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdy_v[0]) rc++;
      tick();
    end
    chk("t3_rdy_count", 16'(rc), 16'h1);
    chk("t3_idle_busy", 16'(busy_v[0]), 16'h0);
    txn(0, 1'b0, 16'h3100, 16'h0000, 4, "t3_rd0");
    chk("t3_first_write", rdata_v[0], 16'h7777);
    txn(0, 1'b0, 16'h3101, 16'h0000, 4, "t3_rd1");
    chk("t3_dropped_write", rdata_v[0], 16'h0001);

    // Step 4: reset one cycle after accepting a write aborts it.
    txn(0, 1'b1, 16'h4000, 16'h1111, 4, "t4_pre");
    init_v[0] = 1'b1; wtxn = 1'b1; addr = 16'h4000; wdata = 16'hBEEF;
    tick();
    init_v[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdy_v[0]) rc++;
      tick();
    end
    chk("t4_no_rdy", 16'(rc), 16'h0);
    chk("t4_rdata_rst", rdata_v[0], 16'h0000);
    chk("t4_busy", 16'(busy_v[0]), 16'h0);
    txn(0, 1'b0, 16'h4000, 16'h0000, 4, "t4_rd");
    chk("t4_old_value", rdata_v[0], 16'h1111);

    // Request coincident with reset is discarded.
    rst = 1'b1;
    init_v[0] = 1'b1; wtxn = 1'b1; addr = 16'h4000; wdata = 16'hDEAD;
    tick();
    rst = 1'b0;
    init_v[0] = 1'b0;
    rc = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy_v[0] || busy_v[0]) rc++;
      tick();
    end
    chk("t4b_discarded", 16'(rc), 16'h0);
    txn(0, 1'b0, 16'h4000, 16'h0000, 4, "t4b_rd");
    chk("t4b_mem_intact", rdata_v[0], 16'h1111);

    // Step 5: 8-bit address aliasing.
    txn(2, 1'b1, 16'h0105, 16'hAAAA, 3, "t5_wr");
    txn(2, 1'b0, 16'h0005, 16'h0000, 3, "t5_rd");
    chk("t5_alias_lo", rdata_v[2], 16'hAAAA);
    txn(2, 1'b1, 16'h0006, 16'hBBBB, 3, "t5_wr2");
    chk("t5_write_keeps_rdata", rdata_v[2], 16'hAAAA);
    txn(2, 1'b0, 16'h1206, 16'h0000, 3, "t5_rd2");
    chk("t5_alias_hi", rdata_v[2], 16'hBBBB);

`ifdef STI_MEM_RESP_WP_EN
    // Step 6: write protection below x3000.
    txn(0, 1'b1, 16'h2FFF, 16'h0123, 4, "t6_pre");
    chk("t6_pre_fault", 16'(wp_fault_v[0]), 16'h0);
    wp_en = 1'b1;
    txn(0, 1'b1, 16'h2FFF, 16'h5555, 4, "t6_blocked");
    chk("t6_fault", 16'(wp_fault_v[0]), 16'h1);
    txn(0, 1'b0, 16'h2FFF, 16'h0000, 4, "t6_rd");
    chk("t6_read_fault", 16'(wp_fault_v[0]), 16'h0);
    chk("t6_unchanged", rdata_v[0], 16'h0123);
    txn(0, 1'b1, 16'h3000, 16'h6666, 4, "t6_ok");
    chk("t6_ok_fault", 16'(wp_fault_v[0]), 16'h0);
    txn(0, 1'b0, 16'h3000, 16'h0000, 4, "t6_rd2");
    chk("t6_committed", rdata_v[0], 16'h6666);
    wp_en = 1'b0;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
